// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - detector state type and "010" transition function
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S0   = 2'b01,
        S01  = 2'b10
    } state_t;

    typedef struct packed {
        state_t next;
        logic   detect;
    } det_res_t;

    // Overlapping detector: the trailing 0 of a match is the leading 0 of the next.
    function automatic det_res_t det_next(input state_t state, input logic bit_in);
        det_res_t r;
        r.next   = IDLE;
        r.detect = 1'b0;
        case (state)
            IDLE: r.next = bit_in ? IDLE : S0;
            S0:   r.next = bit_in ? S01 : S0;
            S01: begin
                r.next   = bit_in ? IDLE : S0;
                r.detect = ~bit_in;
            end
            default: r.next = IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning its rotating priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan from the pointer upward, wrapping at N; first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/seq_det_channel_scheduler.sv
// rtl/seq_det_channel_scheduler.sv - shared "010" detector step scheduled across serial channels
module seq_det_channel_scheduler
    import seq_det_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH-1:0]         ch_bit,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH-1:0]         clr_ch,
    output logic                      det_valid,
    output logic [$clog2(NUM_CH)-1:0] det_ch,
    output logic [NUM_CH*CNT_W-1:0]   det_count
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           st  [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    det_res_t          res;

    // Gating with rst_n keeps ch_ready low throughout reset; a clear blocks that channel's grant.
    always_comb begin
        eligible = '0;
        if (enable && rst_n) begin
            eligible = ch_valid & ~clr_ch;
        end
    end

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign ch_ready = gnt;

    always_comb begin
        res = det_next(st[gnt_idx], ch_bit[gnt_idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_ch[i]) begin
                    st[i]  <= IDLE;
                    cnt[i] <= '0;
                end else if (gnt[i]) begin
                    st[i] <= res.next;
                    if (res.detect && (cnt[i] != CNT_MAX)) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= gnt_any & res.detect;
            if (gnt_any && res.detect) begin
                det_ch <= gnt_idx;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        assign det_count[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_seq_det_channel_scheduler.sv
// tb/tb_seq_det_channel_scheduler.sv - self-checking bench for seq_det_channel_scheduler
module tb_seq_det_channel_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       enable;
    logic [3:0] ch_valid, ch_bit, clr_ch;
    logic [3:0] rdy_a, rdy_b;
    logic       dv_a, dv_b;
    logic [1:0] dch_a, dch_b;
    logic [31:0] cnt_a;
    logic [7:0]  cnt_b;

    seq_det_channel_scheduler #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_valid(ch_valid), .ch_bit(ch_bit),
        .ch_ready(rdy_a), .clr_ch(clr_ch), .det_valid(dv_a), .det_ch(dch_a), .det_count(cnt_a)
    );

    seq_det_channel_scheduler #(.NUM_CH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_valid(ch_valid), .ch_bit(ch_bit),
        .ch_ready(rdy_b), .clr_ch(clr_ch), .det_valid(dv_b), .det_ch(dch_b), .det_count(cnt_b)
    );

    int total = 0;
    int bad   = 0;

    // Model: per-channel bit history since last clear, raw detection totals, rotating pointer.
    int ptr;
    int hist [N];
    int nb   [N];
    int raw  [N];
    bit m_dv;
    int m_dch;

    logic [3:0] obs_rdy;
    logic       obs_dv;
    logic [1:0] obs_dch;
    int         obs_cnt_a [N];
    int         obs_cnt_b [N];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        ptr   = 0;
        m_dv  = 0;
        m_dch = 0;
        for (int i = 0; i < N; i++) begin
            hist[i] = 0;
            nb[i]   = 0;
            raw[i]  = 0;
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [3:0] v,
                        input logic [3:0] b, input logic [3:0] c);
        int g;
        int idx;
        int exp_rdy;
        @(posedge clk);
        #1;
        rst_n = r; enable = en; ch_valid = v; ch_bit = b; clr_ch = c;
        @(negedge clk);
        obs_rdy = rdy_a;
        obs_dv  = dv_a;
        obs_dch = dch_a;
        for (int i = 0; i < N; i++) begin
            obs_cnt_a[i] = int'(cnt_a[i*8 +: 8]);
            obs_cnt_b[i] = int'(cnt_b[i*2 +: 2]);
        end
        if (!r) begin
            model_reset();
            check("rst_ready", int'(rdy_a), 0);
            check("rst_ready2", int'(rdy_b), 0);
            check("rst_det_valid", int'(dv_a), 0);
            check("rst_det_valid2", int'(dv_b), 0);
            check("rst_counts", int'(cnt_a), 0);
            check("rst_counts2", int'(cnt_b), 0);
            return;
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (g < 0 && en && v[idx] && !c[idx]) g = idx;
        end
        exp_rdy = (g < 0) ? 0 : (1 << g);
        check("ch_ready", int'(rdy_a), exp_rdy);
        check("ch_ready2", int'(rdy_b), exp_rdy);
        check("det_valid", int'(dv_a), int'(m_dv));
        check("det_valid2", int'(dv_b), int'(m_dv));
        if (m_dv) begin
            check("det_ch", int'(dch_a), m_dch);
            check("det_ch2", int'(dch_b), m_dch);
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("count8_ch%0d", i), obs_cnt_a[i], min_i(raw[i], 255));
            check($sformatf("count2_ch%0d", i), obs_cnt_b[i], min_i(raw[i], 3));
        end
        m_dv = 0;
        if (g >= 0) begin
            hist[g] = ((hist[g] << 1) | int'(b[g])) & 7;
            nb[g]++;
            if (nb[g] >= 3 && hist[g] == 3'b010) begin
                raw[g]++;
                m_dv  = 1;
                m_dch = g;
            end
            ptr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                hist[i] = 0;
                nb[i]   = 0;
                raw[i]  = 0;
            end
        end
    endtask

    int rr_lit [5]  = '{1, 2, 4, 8, 1};
    int sat_lit [5] = '{1, 2, 3, 3, 3};
    logic [3:0] bits0 [5];
    int pattern;
    int pulses;

    initial begin
        rst_n = 1'b0; enable = 1'b0; ch_valid = '0; ch_bit = '0; clr_ch = '0;
        model_reset();
        step(0, 0, 4'h0, 4'h0, 4'h0);
        check("reset_det_ch", int'(obs_dch), 0);

        // Round-robin rotation with every channel requesting
        for (int s = 0; s < 5; s++) begin
            step(1, 1, 4'hF, 4'($urandom_range(0, 15)), 4'h0);
            check("rr_sequence", int'(obs_rdy), rr_lit[s]);
        end

        // ch0 alone: 0,1,0,1,0 -> detections after the 3rd and 5th consumes
        step(0, 0, 4'h0, 4'h0, 4'h0);
        bits0 = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
        pattern = 0;
        for (int s = 0; s < 6; s++) begin
            if (s < 5) step(1, 1, 4'h1, bits0[s], 4'h0);
            else       step(1, 1, 4'h0, 4'h0, 4'h0);
            if (obs_dv) pattern |= (1 << s);
        end
        check("ch0_pulse_pattern", pattern, 6'b101000);
        check("ch0_count", obs_cnt_a[0], 2);

        // State isolation: ch0 0,1 ; ch1 0 ; ch0 0
        step(1, 1, 4'h0, 4'h0, 4'h3);
        pattern = 0;
        step(1, 1, 4'h1, 4'h0, 4'h0); if (obs_dv) pattern |= 1;
        step(1, 1, 4'h1, 4'h1, 4'h0); if (obs_dv) pattern |= 2;
        step(1, 1, 4'h2, 4'h0, 4'h0); if (obs_dv) pattern |= 4;
        step(1, 1, 4'h1, 4'h0, 4'h0); if (obs_dv) pattern |= 8;
        step(1, 1, 4'h0, 4'h0, 4'h0); if (obs_dv) pattern |= 16;
        check("isolation_pattern", pattern, 5'b10000);
        check("isolation_det_ch", int'(obs_dch), 0);

        // Clear beats grant on ch1 sitting in S01
        step(1, 1, 4'h2, 4'h2, 4'h0);
        step(1, 1, 4'h2, 4'h0, 4'h2);
        check("clear_blocks_ready", int'(obs_rdy[1]), 0);
        step(1, 1, 4'h0, 4'h0, 4'h0);
        check("clear_no_det", int'(obs_dv), 0);
        check("clear_count1", obs_cnt_a[1], 0);
        step(1, 1, 4'h2, 4'h0, 4'h0);
        step(1, 1, 4'h0, 4'h0, 4'h0);
        check("after_clear_0_no_det", int'(obs_dv), 0);

        // Saturation on the CNT_W=2 instance, ch2 fed 01010101010
        step(1, 1, 4'h0, 4'h0, 4'h4);
        for (int k = 0; k < 12; k++) begin
            if (k < 11) step(1, 1, 4'h4, (k % 2) ? 4'h4 : 4'h0, 4'h0);
            else        step(1, 1, 4'h0, 4'h0, 4'h0);
            if (k >= 3 && (k % 2) == 1) check("sat_count2", obs_cnt_b[2], sat_lit[(k-3)/2]);
        end
        check("sat_count8", obs_cnt_a[2], 5);

        // enable=0 holds everything
        for (int s = 0; s < 3; s++) begin
            step(1, 0, 4'hF, 4'($urandom_range(0, 15)), 4'h0);
            check("disabled_ready", int'(obs_rdy), 0);
        end

        // Reset mid-stream drops a pending detection
        step(1, 1, 4'h0, 4'h0, 4'h8);
        step(1, 1, 4'h8, 4'h0, 4'h0);
        step(1, 1, 4'h8, 4'h8, 4'h0);
        step(1, 1, 4'h8, 4'h0, 4'h0);
        step(0, 1, 4'h8, 4'h0, 4'h0);
        check("midrst_dv", int'(obs_dv), 0);
        check("midrst_count3", obs_cnt_a[3], 0);
        pulses = 0;
        step(1, 1, 4'h8, 4'h8, 4'h0); if (obs_dv) pulses++;
        step(1, 1, 4'h8, 4'h0, 4'h0); if (obs_dv) pulses++;
        step(1, 1, 4'h0, 4'h0, 4'h0); if (obs_dv) pulses++;
        check("post_reset_no_early_det", pulses, 0);

        // Randomized traffic against the model
        for (int s = 0; s < 600; s++) begin
            step(($urandom % 100) != 0, ($urandom % 8) != 0,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 (($urandom % 6) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
